// File: rtl/instruction_memory_loader.sv
// instruction_memory_loader
// Parametrised instruction memory with a registered 1-cycle fetch port and a
// sequential program-load engine (IDLE -> LOAD -> DONE -> IDLE).
// Optional macro: INSTR_MEM_PARITY_EN adds a stored even-parity bit per word
// and a registered parity_err output alongside fetch_data.
//
// Handshakes: fetch_req is taken on a rising edge while fetch_ready=1, and
// fetch_valid/fetch_data appear after the next edge. A load word is taken on
// a rising edge when load_valid && load_ready. No other inputs are acknowledged.

module instruction_memory_loader #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ready,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_data,
`ifdef INSTR_MEM_PARITY_EN
    output logic                  parity_err,
`endif
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    output logic                  load_done,
    output logic                  loading
);

`ifdef INSTR_MEM_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif

    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Current state is kept as a named register so checkers can bind to it.
    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH:0]   remaining;

    logic [MEM_W-1:0] mem [0:DEPTH-1];

    logic fetch_in_range;
    logic base_in_range;
    logic fetch_fire;
    logic write_en;
    logic [MEM_W-1:0] write_word;

    assign fetch_in_range = {1'b0, fetch_addr} < DEPTH_W;
    assign base_in_range  = {1'b0, load_base} < DEPTH_W;
    assign fetch_fire     = (state == IDLE) && fetch_req;
    // A reset edge aborts the load, so the word presented on it is dropped.
    assign write_en       = (state == LOAD) && load_valid && !reset;

`ifdef INSTR_MEM_PARITY_EN
    assign write_word = {^load_data, load_data};
`else
    assign write_word = load_data;
`endif

    // Load sequencer: captures base/length, walks the write pointer, and drives
    // the registered handshake/status outputs for the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            remaining   <= '0;
            fetch_ready <= 1'b1;
            load_ready  <= 1'b0;
            load_done   <= 1'b0;
            loading     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        // An out-of-range base would address nothing; start at 0.
                        ptr         <= base_in_range ? load_base : '0;
                        remaining   <= load_len;
                        fetch_ready <= 1'b0;
                        loading     <= 1'b1;
                        if (load_len == '0) begin
                            state      <= DONE;
                            load_done  <= 1'b1;
                            load_ready <= 1'b0;
                        end else begin
                            state      <= LOAD;
                            load_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (load_valid) begin
                        ptr       <= (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == (ADDR_WIDTH+1)'(1)) begin
                            state      <= DONE;
                            load_ready <= 1'b0;
                            load_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    load_done   <= 1'b0;
                    loading     <= 1'b0;
                    fetch_ready <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    load_ready  <= 1'b0;
                    load_done   <= 1'b0;
                    loading     <= 1'b0;
                    fetch_ready <= 1'b1;
                end
            endcase
        end
    end

    // Single write port; contents survive reset so partial loads remain.
    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[ptr] <= write_word;
        end
    end

    // Registered read port; fetch_data holds its value between fetches.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
`ifdef INSTR_MEM_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            fetch_valid <= fetch_fire;
            if (fetch_fire) begin
                fetch_data <= fetch_in_range ? mem[fetch_addr][DATA_WIDTH-1:0] : NOP_WORD;
            end
`ifdef INSTR_MEM_PARITY_EN
            parity_err <= fetch_fire && fetch_in_range && (^mem[fetch_addr]);
`endif
        end
    end

endmodule
